// File: rtl/tlb_ctrl_pkg.sv
// tlb_ctrl_pkg: op codes, FSM states and CSR field positions shared by the TLB op controller.
package tlb_ctrl_pkg;
  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD = 3'd1;
  localparam logic [2:0] OP_WR = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV = 3'd4;
  localparam logic [4:0] INV_OP_MAX = 5'd6;
  typedef enum logic [2:0] {S_IDLE, S_SRCH, S_RD, S_CMD, S_DONE} state_e;
  localparam int TLBIDX_NE = 31;
  localparam int TLBIDX_PS_LSB = 24;
  localparam int TLBIDX_PS_W = 6;
  localparam int TLBIDX_INDEX_W = 5;
  localparam int EHI_VPPN_LSB = 13;
  localparam int ELO_PPN_LSB = 8;
  localparam int ELO_G = 6;
  localparam int ELO_MAT_LSB = 4;
  localparam int ELO_PLV_LSB = 2;
  localparam int ELO_D = 1;
  localparam int ELO_V = 0;
  localparam int ASID_W = 10;
  function automatic logic [31:0] elo_pack(input logic [19:0] ppn, input logic g, input logic [1:0] mat,
                                           input logic [1:0] plv, input logic d, input logic v);
    logic [31:0] e;
    e = '0;
    e[ELO_PPN_LSB +: 20] = ppn;
    e[ELO_G] = g;
    e[ELO_MAT_LSB +: 2] = mat;
    e[ELO_PLV_LSB +: 2] = plv;
    e[ELO_D] = d;
    e[ELO_V] = v;
    return e;
  endfunction
endpackage

// File: rtl/tlb_op_ctrl_if.sv
// tlb_op_ctrl_if: TLB-instruction request/completion handshake between pipeline and tlb_op_ctrl.
interface tlb_op_ctrl_if;
  logic op_valid;
  logic op_ready;
  logic [2:0] op_code;
  logic [4:0] inv_op;
  logic [9:0] inv_asid;
  logic [18:0] inv_vpn;
  logic op_done;
  logic op_ine;
  modport master(output op_valid, op_code, inv_op, inv_asid, inv_vpn, input op_ready, op_done, op_ine);
  modport slave(input op_valid, op_code, inv_op, inv_asid, inv_vpn, output op_ready, op_done, op_ine);
endinterface

// File: rtl/tlb_rand_gen.sv
// tlb_rand_gen: TLBFILL victim index, held while a fill is issued.
// TLBFILL_LFSR_EN selects an x^5+x^3+1 LFSR (seed 1); otherwise a wrapping counter from 0.
module tlb_rand_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  output logic [4:0] idx
);
`ifdef TLBFILL_LFSR_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) idx <= 5'b00001;
    else if (!hold) idx <= {idx[3:0], idx[4] ^ idx[2]};
`else
  always_ff @(posedge clk or negedge reset)
    if (!reset) idx <= 5'd0;
    else if (!hold) idx <= idx + 5'd1;
`endif
endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB into translator commands and CSR write-back.
// Build option TLBFILL_LFSR_EN picks the rand_index generator flavour inside tlb_rand_gen.
module tlb_op_ctrl
  import tlb_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  tlb_op_ctrl_if.slave op,
  input  logic         flush,
  input  logic [31:0]  csr_tlbidx,
  input  logic [31:0]  csr_tlbehi,
  output logic         data_tlbserch_en,
  output logic         tlb_wen,
  output logic         tlb_fill_en,
  output logic [4:0]   rand_index,
  output logic         tlbinv_en,
  output logic [4:0]   tlbinv_op,
  output logic [9:0]   tlbinv_asid,
  output logic [18:0]  tlbinv_vpn,
  input  logic         serch_tlb_finish,
  input  logic         data_tlbfound,
  input  logic [4:0]   data_tlbindex,
  input  logic [18:0]  r_vppn,
  input  logic [9:0]   r_asid,
  input  logic         r_g,
  input  logic [5:0]   r_ps,
  input  logic         r_e,
  input  logic         r_v0,
  input  logic         r_d0,
  input  logic [1:0]   r_mat0,
  input  logic [1:0]   r_plv0,
  input  logic [19:0]  r_ppn0,
  input  logic         r_v1,
  input  logic         r_d1,
  input  logic [1:0]   r_mat1,
  input  logic [1:0]   r_plv1,
  input  logic [19:0]  r_ppn1,
  output logic         tlbidx_we,
  output logic         ehi_we,
  output logic         elo0_we,
  output logic         elo1_we,
  output logic         asid_we,
  output logic [31:0]  tlbidx_wdata,
  output logic [31:0]  ehi_wdata,
  output logic [31:0]  elo0_wdata,
  output logic [31:0]  elo1_wdata,
  output logic [31:0]  asid_wdata
);
  state_e st, nxt;
  logic [2:0] code_q;
  logic ine_q;
  logic [4:0] iop_q;
  logic [9:0] iasid_q;
  logic [18:0] ivpn_q;
  logic acc, illegal, done, ine;
  assign acc = op.op_valid && op.op_ready;
  assign illegal = op.op_code > OP_INV || (op.op_code == OP_INV && op.inv_op > INV_OP_MAX);
  assign op.op_ready = st == S_IDLE;
  assign op.op_done = done;
  assign op.op_ine = ine;
  assign tlbinv_op = tlbinv_en ? iop_q : '0;
  assign tlbinv_asid = tlbinv_en ? iasid_q : '0;
  assign tlbinv_vpn = tlbinv_en ? ivpn_q : '0;
  tlb_rand_gen u_rand (.clk(clk), .reset(reset), .hold(tlb_fill_en), .idx(rand_index));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= S_IDLE;
      code_q <= '0;
      ine_q <= 1'b0;
      iop_q <= '0;
      iasid_q <= '0;
      ivpn_q <= '0;
    end else begin
      st <= nxt;
      if (acc) begin
        code_q <= op.op_code;
        ine_q <= illegal;
        iop_q <= op.inv_op;
        iasid_q <= op.inv_asid;
        ivpn_q <= op.inv_vpn;
      end
    end
  // flush cancels whatever the current state would issue this cycle
  always_comb begin
    nxt = st;
    data_tlbserch_en = 1'b0;
    tlb_wen = 1'b0;
    tlb_fill_en = 1'b0;
    tlbinv_en = 1'b0;
    {tlbidx_we, ehi_we, elo0_we, elo1_we, asid_we} = '0;
    tlbidx_wdata = '0;
    ehi_wdata = '0;
    elo0_wdata = '0;
    elo1_wdata = '0;
    asid_wdata = '0;
    done = 1'b0;
    ine = 1'b0;
    case (st)
      S_IDLE: if (acc) nxt = illegal ? S_DONE : op.op_code == OP_SRCH ? S_SRCH : op.op_code == OP_RD ? S_RD : S_CMD;
      S_SRCH: begin
        data_tlbserch_en = !flush;
        if (flush) nxt = S_IDLE;
        else if (serch_tlb_finish) begin
          nxt = S_DONE;
          tlbidx_we = 1'b1;
          tlbidx_wdata = csr_tlbidx;
          tlbidx_wdata[TLBIDX_NE] = !data_tlbfound;
          if (data_tlbfound) tlbidx_wdata[TLBIDX_INDEX_W-1:0] = data_tlbindex;
        end
      end
      S_RD: begin
        nxt = flush ? S_IDLE : S_DONE;
        {tlbidx_we, ehi_we, elo0_we, elo1_we, asid_we} = {5{!flush}};
        if (!flush) begin
          tlbidx_wdata = csr_tlbidx;
          tlbidx_wdata[TLBIDX_NE] = !r_e;
          tlbidx_wdata[TLBIDX_PS_LSB +: TLBIDX_PS_W] = r_e ? r_ps : '0;
          if (r_e) begin
            ehi_wdata = {r_vppn, csr_tlbehi[EHI_VPPN_LSB-1:0]};
            elo0_wdata = elo_pack(r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0);
            elo1_wdata = elo_pack(r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1);
            asid_wdata[ASID_W-1:0] = r_asid;
          end
        end
      end
      S_CMD: begin
        nxt = flush ? S_IDLE : S_DONE;
        tlb_wen = !flush && code_q == OP_WR;
        tlb_fill_en = !flush && code_q == OP_FILL;
        tlbinv_en = !flush && code_q == OP_INV;
      end
      S_DONE: begin
        nxt = S_IDLE;
        done = !flush;
        ine = !flush && ine_q;
      end
      default: nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: randomized scoreboard bench for tlb_op_ctrl against a CSR-field-level reference model.
module tb_tlb_op_ctrl;
  logic clk = 0, reset = 0, flush = 0;
  logic [31:0] csr_tlbidx = 0, csr_tlbehi = 0;
  logic data_tlbserch_en, tlb_wen, tlb_fill_en, tlbinv_en;
  logic [4:0] rand_index, tlbinv_op;
  logic [9:0] tlbinv_asid;
  logic [18:0] tlbinv_vpn;
  logic serch_tlb_finish = 0, data_tlbfound = 0;
  logic [4:0] data_tlbindex = 0;
  logic [18:0] r_vppn = 0;
  logic [9:0] r_asid = 0;
  logic r_g = 0, r_e = 0, r_v0 = 0, r_d0 = 0, r_v1 = 0, r_d1 = 0;
  logic [5:0] r_ps = 0;
  logic [1:0] r_mat0 = 0, r_plv0 = 0, r_mat1 = 0, r_plv1 = 0;
  logic [19:0] r_ppn0 = 0, r_ppn1 = 0;
  logic tlbidx_we, ehi_we, elo0_we, elo1_we, asid_we;
  logic [31:0] tlbidx_wdata, ehi_wdata, elo0_wdata, elo1_wdata, asid_wdata;
  tlb_op_ctrl_if opif();
  tlb_op_ctrl dut (
    .clk(clk), .reset(reset), .op(opif), .flush(flush), .csr_tlbidx(csr_tlbidx), .csr_tlbehi(csr_tlbehi),
    .data_tlbserch_en(data_tlbserch_en), .tlb_wen(tlb_wen), .tlb_fill_en(tlb_fill_en), .rand_index(rand_index),
    .tlbinv_en(tlbinv_en), .tlbinv_op(tlbinv_op), .tlbinv_asid(tlbinv_asid), .tlbinv_vpn(tlbinv_vpn),
    .serch_tlb_finish(serch_tlb_finish), .data_tlbfound(data_tlbfound), .data_tlbindex(data_tlbindex),
    .r_vppn(r_vppn), .r_asid(r_asid), .r_g(r_g), .r_ps(r_ps), .r_e(r_e),
    .r_v0(r_v0), .r_d0(r_d0), .r_mat0(r_mat0), .r_plv0(r_plv0), .r_ppn0(r_ppn0),
    .r_v1(r_v1), .r_d1(r_d1), .r_mat1(r_mat1), .r_plv1(r_plv1), .r_ppn1(r_ppn1),
    .tlbidx_we(tlbidx_we), .ehi_we(ehi_we), .elo0_we(elo0_we), .elo1_we(elo1_we), .asid_we(asid_we),
    .tlbidx_wdata(tlbidx_wdata), .ehi_wdata(ehi_wdata), .elo0_wdata(elo0_wdata), .elo1_wdata(elo1_wdata),
    .asid_wdata(asid_wdata)
  );
  always #5 clk = ~clk;
  typedef struct {
    int kind;
    logic [4:0] we;
    logic [31:0] idx, ehi, elo0, elo1, asid;
    logic [2:0] cmd;
    logic [4:0] iop;
    logic [9:0] iasid;
    logic [18:0] ivpn;
    logic ine;
  } exp_t;
  exp_t exp_q[$];
  exp_t me;
  int tests = 0, fails = 0, adv = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction
  function automatic void bad(string nm);
    tests++;
    fails++;
    $display("FAIL %s actual=timeout/unexpected required=in-order response", nm);
  endfunction
  function automatic bit front_is(int k, string nm);
    if (exp_q.size() != 0 && exp_q[0].kind == k) return 1;
    bad(nm);
    return 0;
  endfunction
  function automatic logic [31:0] elo_ref(logic [19:0] ppn, logic g, logic [1:0] mat, logic [1:0] plv, logic d, logic v);
    return 32'(ppn) * 256 + 32'(g) * 64 + 32'(mat) * 16 + 32'(plv) * 4 + 32'(d) * 2 + 32'(v);
  endfunction
  // number of generator advances since reset: one per edge without an issued fill
  always @(posedge clk or negedge reset)
    if (!reset) adv <= 0;
    else if (!tlb_fill_en) adv <= adv + 1;
  always @(negedge clk) if (reset) begin
    if ({tlbidx_we, ehi_we, elo0_we, elo1_we, asid_we} != 0 && front_is(0, "csr_write")) begin
      me = exp_q.pop_front();
      chk("we", {27'd0, tlbidx_we, ehi_we, elo0_we, elo1_we, asid_we}, {27'd0, me.we});
      chk("tlbidx_wdata", tlbidx_wdata, me.idx);
      chk("ehi_wdata", ehi_wdata, me.ehi);
      chk("elo0_wdata", elo0_wdata, me.elo0);
      chk("elo1_wdata", elo1_wdata, me.elo1);
      chk("asid_wdata", asid_wdata, me.asid);
    end
    if ({tlbinv_en, tlb_fill_en, tlb_wen} != 0 && front_is(1, "command")) begin
      me = exp_q.pop_front();
      chk("cmd", {29'd0, tlbinv_en, tlb_fill_en, tlb_wen}, {29'd0, me.cmd});
      chk("tlbinv_op", 32'(tlbinv_op), 32'(me.iop));
      chk("tlbinv_asid", 32'(tlbinv_asid), 32'(me.iasid));
      chk("tlbinv_vpn", 32'(tlbinv_vpn), 32'(me.ivpn));
      if (tlb_fill_en) begin
`ifdef TLBFILL_LFSR_EN
        chk("rand_index_nonzero", 32'(rand_index == 5'd0), 0);
`else
        chk("rand_index", 32'(rand_index), adv % 32);
`endif
      end
    end
    if (opif.op_done && front_is(2, "op_done")) begin
      me = exp_q.pop_front();
      chk("op_ine", 32'(opif.op_ine), 32'(me.ine));
    end
    if (opif.op_ine && !opif.op_done) bad("op_ine_without_done");
  end
  task automatic run_op(input logic [2:0] c, input logic [4:0] iop, input int dly, input bit fl);
    exp_t e;
    bit ill;
    int n;
    e = '{default: '0};
    ill = c > 3'd4 || (c == 3'd4 && iop > 5'd6);
    if (!ill && !fl && c == 3'd0) begin
      e.kind = 0;
      e.we = 5'b10000;
      e.idx = data_tlbfound ? ((csr_tlbidx & ~32'h8000_001F) | 32'(data_tlbindex)) : (csr_tlbidx | 32'h8000_0000);
      exp_q.push_back(e);
    end
    if (!ill && c == 3'd1) begin
      e.kind = 0;
      e.we = 5'b11111;
      e.idx = (csr_tlbidx & 32'h40FF_FFFF) | (r_e ? 32'(r_ps) << 24 : 32'h8000_0000);
      e.ehi = r_e ? ((csr_tlbehi & 32'h1FFF) | (32'(r_vppn) << 13)) : 0;
      e.elo0 = r_e ? elo_ref(r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0) : 0;
      e.elo1 = r_e ? elo_ref(r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1) : 0;
      e.asid = r_e ? 32'(r_asid) : 0;
      exp_q.push_back(e);
    end
    if (!ill && c >= 3'd2) begin
      e = '{default: '0};
      e.kind = 1;
      e.cmd = c == 3'd2 ? 3'b001 : c == 3'd3 ? 3'b010 : 3'b100;
      if (c == 3'd4) begin
        e.iop = iop;
        e.iasid = opif.inv_asid;
        e.ivpn = opif.inv_vpn;
      end
      exp_q.push_back(e);
    end
    if (!fl) begin
      e = '{default: '0};
      e.kind = 2;
      e.ine = ill;
      exp_q.push_back(e);
    end
    n = 0;
    while (!opif.op_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) bad("ready_timeout");
    opif.op_valid = 1;
    opif.op_code = c;
    opif.inv_op = iop;
    @(posedge clk); #1;
    opif.op_valid = 0;
    if (c == 3'd0) begin
      n = 0;
      while (!data_tlbserch_en && n < 20) begin @(posedge clk); #1; n++; end
      if (n == 20) bad("search_en_timeout");
      repeat (dly) begin @(posedge clk); #1; end
      if (fl) begin
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("ready_after_flush", 32'(opif.op_ready), 1);
      end else begin
        serch_tlb_finish = 1;
        @(posedge clk); #1;
        serch_tlb_finish = 0;
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) bad("drain_timeout");
  endtask
  task automatic rand_inputs();
    csr_tlbidx = $urandom;
    csr_tlbehi = $urandom;
    data_tlbfound = 1'($urandom);
    data_tlbindex = 5'($urandom);
    r_vppn = 19'($urandom);
    r_asid = 10'($urandom);
    {r_g, r_e, r_v0, r_d0, r_v1, r_d1} = 6'($urandom);
    r_ps = 6'($urandom);
    {r_mat0, r_plv0, r_mat1, r_plv1} = 8'($urandom);
    r_ppn0 = 20'($urandom);
    r_ppn1 = 20'($urandom);
    opif.inv_asid = 10'($urandom);
    opif.inv_vpn = 19'($urandom);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
  initial begin
    bit fl;
    logic [2:0] c;
    opif.op_valid = 0;
    opif.op_code = 0;
    opif.inv_op = 0;
    opif.inv_asid = 0;
    opif.inv_vpn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", 32'(opif.op_ready), 1);
    chk("rst_op_done", 32'(opif.op_done), 0);
    chk("rst_enables", {26'd0, data_tlbserch_en, tlb_wen, tlb_fill_en, tlbinv_en, tlbidx_we, asid_we}, 0);
    chk("rst_wdata", tlbidx_wdata | ehi_wdata | elo0_wdata | elo1_wdata | asid_wdata, 0);
`ifdef TLBFILL_LFSR_EN
    chk("rst_rand_seed", 32'(rand_index), 1);
`else
    chk("rst_rand_seed", 32'(rand_index), 0);
`endif
    reset = 1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(opif.op_ready), 1);
    csr_tlbidx = 0; data_tlbfound = 1; data_tlbindex = 5'd9;
    run_op(3'd0, 5'd0, 1, 0);
    csr_tlbidx = 32'h0C00_0003; data_tlbfound = 0;
    run_op(3'd0, 5'd0, 0, 0);
    rand_inputs();
    csr_tlbidx = 0; csr_tlbehi = 0;
    r_e = 1; r_vppn = 19'h12345; r_ps = 6'd12; r_asid = 10'h3A;
    run_op(3'd1, 5'd0, 0, 0);
    r_e = 0;
    run_op(3'd1, 5'd0, 0, 0);
    repeat (5) run_op(3'd3, 5'd0, 0, 0);
    run_op(3'd2, 5'd0, 0, 0);
    opif.inv_asid = 10'h11; opif.inv_vpn = 19'h4;
    run_op(3'd4, 5'd7, 0, 0);
    run_op(3'd4, 5'd5, 0, 0);
    run_op(3'd6, 5'd0, 0, 0);
    run_op(3'd0, 5'd0, 1, 1);
    r_e = 1;
    opif.op_valid = 1; opif.op_code = 3'd1;
    @(posedge clk); #1;
    opif.op_valid = 0;
    reset = 0;
    #2;
    chk("midop_reset_we", {27'd0, tlbidx_we, ehi_we, elo0_we, elo1_we, asid_we}, 0);
    @(posedge clk); #1;
    reset = 1;
    chk("ready_after_midop_reset", 32'(opif.op_ready), 1);
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      c = 3'($urandom_range(0, 7));
      fl = c == 3'd0 && $urandom_range(0, 7) == 0;
      run_op(c, 5'($urandom_range(0, 9)), int'($urandom_range(0, 3)), fl);
    end
    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
